// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-to-UART drain and its bit timer.
// Holds the state encoding, UART framing constants and sizing helpers.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_HI   = 3'd1,
        S_RD_WAIT = 3'd2,
        S_START   = 3'd3,
        S_DATA    = 3'd4,
        S_STOP    = 3'd5
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   FRAME_BITS = 10;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fifo_uart_drain_uart_bit_timer.sv
// UART bit-period timer: emits one tick on the last SYS_CLK cycle of every
// bit period while run is high. clear parks the count at zero so the first
// period after a start is always full length.
module uart_bit_timer
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic SYS_CLK,
    input  logic reset,
    input  logic clear_i,
    input  logic run_i,
    output logic tick_o
);

    localparam int            CW   = clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count and terminal-count tick; count returns to zero at LAST.
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = run_i && !clear_i && (cnt_q == LAST);
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_drain.sv
// Drains the capture FIFO onto a UART line (8N1, LSB first). Each pop is a
// timed read-strobe level pulse followed by a settle wait, because the FIFO
// edge-detects the strobe on its own divided clock.
module fifo_uart_drain
    import fifo_uart_pkg::*;
#(
    parameter int DBITS        = 3,
    parameter int CLKS_PER_BIT = 434,
    parameter int RD_HOLD      = 4,
    parameter int RD_WAIT      = 8
) (
    input  logic             SYS_CLK,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [DBITS-1:0] fifo_dout,
    output logic             fifo_rd,
    output logic             tx,
    output logic             busy,
    output logic             frame_done,
    output logic [7:0]       last_word
);

    localparam int            CW        = clog2(max3(CLKS_PER_BIT, RD_HOLD, RD_WAIT)) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(RD_HOLD - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(RD_WAIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(FRAME_BITS - 3);

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    cap_q, cap_d;
    logic [7:0]    last_q, last_d;
    logic          tx_q, tx_d;
    logic          rd_q, rd_d;
    logic          busy_q, busy_d;
    logic          empty_s1_q, empty_s_q;
    logic [7:0]    din_pad;
    logic          timer_run;
    logic          bit_tick;
    logic          frame_done_c;

    // Empty flag comes from the FIFO's clock domain; resets to "empty" so
    // nothing is popped before the synchronizer has real data.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            empty_s1_q <= 1'b1;
            empty_s_q  <= 1'b1;
        end else begin
            empty_s1_q <= fifo_empty;
            empty_s_q  <= empty_s1_q;
        end
    end

    // Zero-pad the FIFO word up to a full UART byte.
    always_comb begin
        din_pad            = '0;
        din_pad[DBITS-1:0] = fifo_dout;
    end

    assign timer_run = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .SYS_CLK(SYS_CLK),
        .reset  (reset),
        .clear_i(!timer_run),
        .run_i  (timer_run),
        .tick_o (bit_tick)
    );

    // Next-state logic; outputs are decoded from the next state so they
    // change on the same edge as the state register.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        cap_d        = cap_q;
        last_d       = last_q;
        frame_done_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                idx_d = '0;
                if (enable && !empty_s_q) begin
                    state_d = S_RD_HI;
                end
            end
            S_RD_HI: begin
                if (cyc_q == HOLD_LAST) begin
                    cyc_d   = '0;
                    state_d = S_RD_WAIT;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (cyc_q == WAIT_LAST) begin
                    cyc_d   = '0;
                    shreg_d = din_pad;
                    cap_d   = din_pad;
                    state_d = S_START;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    frame_done_c = 1'b1;
                    last_d       = cap_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_d   = (state_d == S_RD_HI);
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START: tx_d = START_BIT;
            S_DATA:  tx_d = shreg_d[0];
            default: tx_d = STOP_BIT;
        endcase
    end

    // Control state and registered outputs; reset drives tx high at once.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
        end
    end

    // Datapath registers; always loaded before use, so no reset needed.
    always_ff @(posedge SYS_CLK) begin
        shreg_q <= shreg_d;
        cap_q   <= cap_d;
    end

    assign fifo_rd    = rd_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_c;
    assign last_word  = last_q;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain with CLKS_PER_BIT=4, DBITS=3.
module tb_fifo_uart_drain;

    localparam int DBITS = 3;
    localparam int CPB   = 4;
    localparam int RDH   = 4;
    localparam int RDW   = 8;
    localparam int FCYC  = 10 * CPB;

    logic             SYS_CLK = 1'b0;
    logic             reset;
    logic             enable;
    logic             fifo_empty;
    logic [DBITS-1:0] fifo_dout;
    logic             fifo_rd;
    logic             tx;
    logic             busy;
    logic             frame_done;
    logic [7:0]       last_word;

    int   nvec     = 0;
    int   nerr     = 0;
    int   rd_rises = 0;
    logic rd_prev  = 1'b0;

    always #5 SYS_CLK = ~SYS_CLK;

    always @(posedge SYS_CLK) begin
        rd_prev <= fifo_rd;
        if (fifo_rd === 1'b1 && rd_prev === 1'b0) rd_rises <= rd_rises + 1;
    end

    fifo_uart_drain #(
        .DBITS(DBITS), .CLKS_PER_BIT(CPB), .RD_HOLD(RDH), .RD_WAIT(RDW)
    ) dut (
        .SYS_CLK(SYS_CLK), .reset(reset), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
        .tx(tx), .busy(busy), .frame_done(frame_done), .last_word(last_word)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic skip(input int n);
        repeat (n) @(negedge SYS_CLK);
    endtask

    // Returns the number of negedges until fifo_rd is seen high, -1 on timeout.
    task automatic wait_rd_rise(input int maxc, output int waited);
        waited = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge SYS_CLK);
            if (fifo_rd === 1'b1) begin
                waited = i;
                break;
            end
        end
    endtask

    // Called at the negedge of the first start-bit cycle; records the 10 line
    // bits, whether tx moved inside a bit, and where frame_done appeared.
    task automatic capture_frame(input int drop_at, output logic [9:0] bits,
                                 output int unstable, output int fd_last, output int fd_other);
        bits = '0; unstable = 0; fd_last = 0; fd_other = 0;
        for (int c = 0; c < FCYC; c++) begin
            if (c > 0) @(negedge SYS_CLK);
            if (c == drop_at) enable = 1'b0;
            if (c % CPB == 0) bits[c / CPB] = tx;
            else if (tx !== bits[c / CPB]) unstable++;
            if (frame_done === 1'b1) begin
                if (c == FCYC - 1) fd_last = 1;
                else fd_other++;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
        repeat (3) @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        nvec++; if (tx !== 1'b1) begin nerr++; $display("FAIL reset_tx: got %b want 1", tx); end
        nvec++; if (fifo_rd !== 1'b0) begin nerr++; $display("FAIL reset_rd: got %b want 0", fifo_rd); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        nvec++; if (last_word !== 8'h00) begin nerr++; $display("FAIL reset_last: got %h want 00", last_word); end
        reset = 1'b0; enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge SYS_CLK);
            nvec++; if (tx !== 1'b1) begin nerr++; $display("FAIL idle_tx cyc %0d: got %b want 1", i, tx); end
            nvec++; if (fifo_rd !== 1'b0) begin nerr++; $display("FAIL idle_rd cyc %0d: got %b want 0", i, fifo_rd); end
            nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL idle_busy cyc %0d: got %b want 0", i, busy); end
        end
        enable = 1'b0;
    endtask

    task automatic test_single_pop;
        int w; int r0; logic [9:0] b; int us; int fl; int fo;
        r0 = rd_rises;
        fifo_dout = 3'b101; fifo_empty = 1'b0; enable = 1'b1;
        wait_rd_rise(10, w);
        nvec++; if (w != 3) begin nerr++; $display("FAIL single_rd_latency: got %0d want 3", w); end
        enable = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge SYS_CLK);
            nvec++; if (fifo_rd !== 1'b1) begin nerr++; $display("FAIL single_rd_hold k=%0d: got %b want 1", k, fifo_rd); end
        end
        @(negedge SYS_CLK);
        nvec++; if (fifo_rd !== 1'b0) begin nerr++; $display("FAIL single_rd_fall: got %b want 0", fifo_rd); end
        skip(6);
        @(negedge SYS_CLK);
        nvec++; if (tx !== 1'b1) begin nerr++; $display("FAIL single_tx_early: got %b want 1", tx); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy: got %b want 1", busy); end
        @(negedge SYS_CLK);
        nvec++; if (tx !== 1'b0) begin nerr++; $display("FAIL single_tx_fall: got %b want 0", tx); end
        capture_frame(-1, b, us, fl, fo);
        nvec++; if (b !== 10'b1000001010) begin nerr++; $display("FAIL single_bits: got %b want 1000001010", b); end
        nvec++; if (us != 0) begin nerr++; $display("FAIL single_bit_width: got %0d glitches want 0", us); end
        nvec++; if (fl != 1 || fo != 0) begin nerr++; $display("FAIL single_frame_done: got last=%0d other=%0d want 1/0", fl, fo); end
        @(negedge SYS_CLK);
        nvec++; if (last_word !== 8'h05) begin nerr++; $display("FAIL single_last_word: got %h want 05", last_word); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL single_busy_end: got %b want 0", busy); end
        nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL single_fd_end: got %b want 0", frame_done); end
        skip(5);
        nvec++; if (rd_rises - r0 != 1) begin nerr++; $display("FAIL single_rd_count: got %0d want 1", rd_rises - r0); end
    endtask

    task automatic test_back_to_back;
        int w; int r0; logic [9:0] b; int us; int fl; int fo;
        r0 = rd_rises;
        fifo_dout = 3'b111; enable = 1'b1;
        wait_rd_rise(10, w);
        nvec++; if (w != 1) begin nerr++; $display("FAIL b2b_rd_latency: got %0d want 1", w); end
        skip(11);
        @(negedge SYS_CLK);
        nvec++; if (tx !== 1'b0) begin nerr++; $display("FAIL b2b_tx_fall1: got %b want 0", tx); end
        fifo_dout = 3'b010;
        capture_frame(-1, b, us, fl, fo);
        nvec++; if (b !== 10'b1000001110) begin nerr++; $display("FAIL b2b_bits1: got %b want 1000001110", b); end
        nvec++; if (fl != 1 || fo != 0) begin nerr++; $display("FAIL b2b_fd1: got last=%0d other=%0d want 1/0", fl, fo); end
        @(negedge SYS_CLK);
        nvec++; if (fifo_rd !== 1'b0) begin nerr++; $display("FAIL b2b_gap: got %b want 0", fifo_rd); end
        nvec++; if (last_word !== 8'h07) begin nerr++; $display("FAIL b2b_last1: got %h want 07", last_word); end
        @(negedge SYS_CLK);
        nvec++; if (fifo_rd !== 1'b1) begin nerr++; $display("FAIL b2b_rd2_rise: got %b want 1", fifo_rd); end
        enable = 1'b0;
        skip(11);
        @(negedge SYS_CLK);
        nvec++; if (tx !== 1'b0) begin nerr++; $display("FAIL b2b_tx_fall2: got %b want 0", tx); end
        capture_frame(-1, b, us, fl, fo);
        nvec++; if (b !== 10'b1000000100) begin nerr++; $display("FAIL b2b_bits2: got %b want 1000000100", b); end
        nvec++; if (us != 0) begin nerr++; $display("FAIL b2b_bit_width: got %0d glitches want 0", us); end
        @(negedge SYS_CLK);
        nvec++; if (last_word !== 8'h02) begin nerr++; $display("FAIL b2b_last2: got %h want 02", last_word); end
        skip(5);
        nvec++; if (rd_rises - r0 != 2) begin nerr++; $display("FAIL b2b_rd_count: got %0d want 2", rd_rises - r0); end
    endtask

    task automatic test_enable_drop;
        int w; int r0; logic [9:0] b; int us; int fl; int fo;
        r0 = rd_rises;
        fifo_dout = 3'b110; enable = 1'b1;
        wait_rd_rise(10, w);
        nvec++; if (w != 1) begin nerr++; $display("FAIL drop_rd_latency: got %0d want 1", w); end
        skip(11);
        @(negedge SYS_CLK);
        nvec++; if (tx !== 1'b0) begin nerr++; $display("FAIL drop_tx_fall: got %b want 0", tx); end
        capture_frame(4 * CPB, b, us, fl, fo);
        nvec++; if (b !== 10'b1000001100) begin nerr++; $display("FAIL drop_bits: got %b want 1000001100", b); end
        nvec++; if (fl != 1 || fo != 0) begin nerr++; $display("FAIL drop_fd: got last=%0d other=%0d want 1/0", fl, fo); end
        @(negedge SYS_CLK);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL drop_busy_end: got %b want 0", busy); end
        skip(60);
        nvec++; if (rd_rises - r0 != 1) begin nerr++; $display("FAIL drop_rd_count: got %0d want 1", rd_rises - r0); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL drop_busy_late: got %b want 0", busy); end
    endtask

    // Leaves a frame in flight for test_reset_mid_start.
    task automatic test_empty_gating;
        int w; int r0;
        fifo_empty = 1'b1;
        skip(3);
        enable = 1'b1;
        r0 = rd_rises;
        skip(200);
        nvec++; if (rd_rises != r0) begin nerr++; $display("FAIL empty_no_pop: got %0d pulses want 0", rd_rises - r0); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL empty_busy: got %b want 0", busy); end
        fifo_dout = 3'b011; fifo_empty = 1'b0;
        wait_rd_rise(10, w);
        nvec++; if (w != 3) begin nerr++; $display("FAIL empty_rd_latency: got %0d want 3", w); end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid_start;
        int w; logic [9:0] b; int us; int fl; int fo;
        skip(11);
        @(negedge SYS_CLK);
        nvec++; if (tx !== 1'b0) begin nerr++; $display("FAIL rst_pre_start: got %b want 0", tx); end
        @(negedge SYS_CLK);
        reset = 1'b1;
        #1;
        nvec++; if (tx !== 1'b1) begin nerr++; $display("FAIL rst_async_tx: got %b want 1", tx); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        nvec++; if (last_word !== 8'h00) begin nerr++; $display("FAIL rst_async_last: got %h want 00", last_word); end
        @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        reset = 1'b0;
        fifo_dout = 3'b100; enable = 1'b1;
        wait_rd_rise(10, w);
        nvec++; if (w != 3) begin nerr++; $display("FAIL rst_rd_latency: got %0d want 3", w); end
        enable = 1'b0;
        skip(11);
        @(negedge SYS_CLK);
        nvec++; if (tx !== 1'b0) begin nerr++; $display("FAIL rst_tx_fall: got %b want 0", tx); end
        capture_frame(-1, b, us, fl, fo);
        nvec++; if (b !== 10'b1000001000) begin nerr++; $display("FAIL rst_bits: got %b want 1000001000", b); end
        nvec++; if (fl != 1 || fo != 0) begin nerr++; $display("FAIL rst_fd: got last=%0d other=%0d want 1/0", fl, fo); end
        @(negedge SYS_CLK);
        nvec++; if (last_word !== 8'h04) begin nerr++; $display("FAIL rst_last: got %h want 04", last_word); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy_end: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_pop();
        test_back_to_back();
        test_enable_drop();
        test_empty_gating();
        test_reset_mid_start();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
